// File: rtl/booth_mult_sequencer_pkg.sv
// Shared multdiv definitions: FSM states, radix-4 Booth digit encodings and
// the default datapath width.
package booth_mult_sequencer_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,  // add 0
    BOOTH_PM   = 3'd1,  // add +M
    BOOTH_P2M  = 3'd2,  // add +2M
    BOOTH_M2M  = 3'd3,  // add -2M
    BOOTH_MM   = 3'd4   // add -M
  } booth_op_e;

  // Map a multiplier triplet {q[i+1], q[i], q[i-1]} to its Booth digit.
  function automatic booth_op_e booth_decode(input logic [2:0] bits);
    booth_op_e op;
    case (bits)
      3'b000, 3'b111: op = BOOTH_ZERO;
      3'b001, 3'b010: op = BOOTH_PM;
      3'b011:         op = BOOTH_P2M;
      3'b100:         op = BOOTH_M2M;
      default:        op = BOOTH_MM;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_mult_sequencer_pp_step.sv
// Combinational partial-product generator for one radix-4 Booth digit.
// Produces the shifted, sign-extended partial product; negative digits are
// returned as the one's complement with carry_in=1 so the accumulator adder
// completes the two's complement negation.
module booth_pp_step
  import booth_mult_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = $clog2(2 * WIDTH)
) (
  input  booth_op_e              booth_op,
  input  logic [WIDTH-1:0]       m,
  input  logic [SHW-1:0]         shamt,
  output logic [2*WIDTH-1:0]     pp,
  output logic                   carry_in
);

  logic signed [2*WIDTH-1:0] m_ext;
  logic signed [2*WIDTH-1:0] mag;
  logic signed [2*WIDTH-1:0] shifted;
  logic                      neg;

  // Select |digit|*M at full 2*WIDTH precision, position it, then invert for negative digits.
  always_comb begin
    m_ext = {{WIDTH{m[WIDTH-1]}}, m};
    mag   = '0;
    neg   = 1'b0;
    case (booth_op)
      BOOTH_PM:  mag = m_ext;
      BOOTH_P2M: mag = m_ext <<< 1;
      BOOTH_M2M: begin
        mag = m_ext <<< 1;
        neg = 1'b1;
      end
      BOOTH_MM: begin
        mag = m_ext;
        neg = 1'b1;
      end
      default: mag = '0;
    endcase
    shifted  = mag <<< shamt;
    pp       = neg ? ~shifted : shifted;
    carry_in = neg;
  end

endmodule

// File: rtl/booth_mult_sequencer.sv
// Multi-cycle signed radix-4 Booth multiplier sequencer. Accepts an operand
// pair in IDLE, retires one Booth digit per cycle in RUN and publishes the
// low product word plus a signed-overflow flag with a one-cycle ready pulse.
module booth_mult_sequencer
  import booth_mult_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_mult,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             data_exception,
  output logic             busy
);

  localparam int STEPS = WIDTH / 2;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int SHW   = $clog2(2 * WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  state_e                   state_q,  state_d;
  logic [CNT_W-1:0]         cnt_q,    cnt_d;
  logic [2*WIDTH-1:0]       acc_q,    acc_d;
  logic [WIDTH-1:0]         m_q,      m_d;
  logic signed [WIDTH:0]    q_q,      q_d;
  logic [WIDTH-1:0]         result_q, result_d;
  logic                     exc_q,    exc_d;
  logic                     rdy_q,    rdy_d;

  booth_op_e                booth_op;
  logic [SHW-1:0]           shamt;
  logic [2*WIDTH-1:0]       pp;
  logic                     carry_in;

  // Product overflows WIDTH bits unless bits [2W-1:W-1] are a pure sign extension.
  function automatic logic signed_ovf(input logic [2*WIDTH-1:0] acc);
    logic [WIDTH:0] upper;
    upper = acc[2*WIDTH-1:WIDTH-1];
    return !((&upper) || (~|upper));
  endfunction

  assign booth_op = booth_decode(q_q[2:0]);
  assign shamt    = SHW'({cnt_q, 1'b0});

  booth_pp_step #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_pp_step (
    .booth_op (booth_op),
    .m        (m_q),
    .shamt    (shamt),
    .pp       (pp),
    .carry_in (carry_in)
  );

  // Next-state and datapath update; everything holds unless the state acts on it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    m_d      = m_q;
    q_d      = q_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_mult) begin
          m_d     = data_operandA;
          q_d     = {data_operandB, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q + pp + (2*WIDTH)'(carry_in);
        q_d   = q_q >>> 2;
        // Hold the counter on the final digit so it never wraps.
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        result_d = acc_q[WIDTH-1:0];
        exc_d    = signed_ovf(acc_q);
        rdy_d    = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers; reset aborts any multiply in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      m_q      <= '0;
      q_q      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      m_q      <= m_d;
      q_q      <= q_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q == RUN);

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Directed and randomized bench for booth_mult_sequencer (WIDTH=32).
module tb_booth_mult_sequencer;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  localparam int NVEC = 17;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_mult = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        data_exception;
  logic        busy;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_res = '0;
  vec_t        vecs[NVEC];

  booth_mult_sequencer #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_mult      (ctrl_mult),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One multiply: accept at edge 0, optionally poke ctrl_mult after edge `poke`,
  // then wait (bounded) for the ready pulse and check timing and results.
  task automatic do_mult(input logic [31:0] ta, input logic [31:0] tb_b,
                         input logic [31:0] er, input logic ee,
                         input int poke, input string tag);
    int edges;
    int busy_cnt;
    bit seen;
    @(negedge clock);
    data_operandA = ta;
    data_operandB = tb_b;
    ctrl_mult     = 1'b1;
    @(posedge clock);
    #1;
    ctrl_mult     = 1'b0;
    data_operandA = ~ta;
    data_operandB = ~tb_b;
    check({tag, " rdy_low_after_accept"}, 64'(data_resultRDY), 64'(0));
    check({tag, " result_held"}, 64'(data_result), 64'(last_res));
    busy_cnt = busy ? 1 : 0;
    edges    = 0;
    seen     = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clock);
      #1;
      if (k == poke) begin
        ctrl_mult     = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
      end else if (k == poke + 1) begin
        ctrl_mult = 1'b0;
      end
      if (data_resultRDY) begin
        seen  = 1'b1;
        edges = k;
      end else if (busy) begin
        busy_cnt++;
      end
    end
    ctrl_mult = 1'b0;
    check({tag, " latency"}, 64'(edges), 64'(17));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(16));
    check({tag, " busy_at_rdy"}, 64'(busy), 64'(0));
    check({tag, " result"}, 64'(data_result), 64'(er));
    check({tag, " exception"}, 64'(data_exception), 64'(ee));
    last_res = er;
  endtask

  // Reference: full signed 64-bit product, low word and overflow flag.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb,
                       output logic [31:0] r, output logic e);
    longint sa;
    longint sb;
    longint p;
    logic [32:0] upper;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    p  = sa * sb;
    r  = p[31:0];
    upper = p[63:31];
    e  = !((upper == 33'h0) || (upper == 33'h1_FFFF_FFFF));
  endtask

  initial begin
    logic [31:0] corners[5];
    logic [31:0] er;
    logic        ee;
    logic [31:0] ra;
    logic [31:0] rb;
    int          rdy_pulses;

    vecs[0]  = '{32'd3,         32'd4,         32'd12,        1'b0};
    vecs[1]  = '{32'hFFFFFFF9,  32'd6,         32'hFFFFFFD6,  1'b0};
    vecs[2]  = '{32'h80000000,  32'd1,         32'h80000000,  1'b0};
    vecs[3]  = '{32'h7FFFFFFF,  32'd2,         32'hFFFFFFFE,  1'b1};
    vecs[4]  = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b1};
    vecs[5]  = '{32'd0,         32'd0,         32'd0,         1'b0};
    vecs[6]  = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         1'b0};
    vecs[7]  = '{32'h7FFFFFFF,  32'h7FFFFFFF,  32'd1,         1'b1};
    vecs[8]  = '{32'h80000000,  32'h80000000,  32'd0,         1'b1};
    vecs[9]  = '{32'h7FFFFFFF,  32'h80000000,  32'h80000000,  1'b1};
    vecs[10] = '{32'd1,         32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0};
    vecs[11] = '{32'h7FFFFFFF,  32'd1,         32'h7FFFFFFF,  1'b0};
    vecs[12] = '{32'h80000000,  32'd2,         32'd0,         1'b1};
    vecs[13] = '{32'h00010000,  32'h00010000,  32'd0,         1'b1};
    vecs[14] = '{32'h0000FFFF,  32'h0000FFFF,  32'hFFFE0001,  1'b1};
    vecs[15] = '{32'h00008000,  32'hFFFF0000,  32'h80000000,  1'b0};
    vecs[16] = '{32'd12345,     32'hFFFFFF9C,  32'hFFED29BC,  1'b0};

    // Reset state, checked asynchronously while reset is held.
    #2;
    check("reset result", 64'(data_result), 64'(0));
    check("reset rdy", 64'(data_resultRDY), 64'(0));
    check("reset exception", 64'(data_exception), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("idle after release busy", 64'(busy), 64'(0));

    // Directed table, issued back-to-back (each start in the cycle after RDY).
    for (int i = 0; i < NVEC; i++) begin
      do_mult(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc, -1, $sformatf("vec%0d", i));
    end

    // Start request during RUN is ignored.
    do_mult(32'd5, 32'd5, 32'd25, 1'b0, 7, "ignore_restart");
    repeat (3) @(posedge clock);
    #1;
    check("ignore_restart no_extra_busy", 64'(busy), 64'(0));

    // Reset asserted mid-multiply aborts without a ready pulse.
    @(negedge clock);
    data_operandA = 32'd100;
    data_operandB = 32'd3;
    ctrl_mult     = 1'b1;
    @(posedge clock);
    #1;
    ctrl_mult = 1'b0;
    repeat (9) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort result", 64'(data_result), 64'(0));
    check("abort exception", 64'(data_exception), 64'(0));
    check("abort busy", 64'(busy), 64'(0));
    check("abort rdy", 64'(data_resultRDY), 64'(0));
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    rdy_pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdy_pulses++;
    end
    check("abort no_rdy_pulse", 64'(rdy_pulses), 64'(0));
    last_res = '0;
    do_mult(32'd6, 32'd7, 32'd42, 1'b0, -1, "after_abort");

    // Corner cross product against the reference model.
    corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        model(corners[i], corners[j], er, ee);
        do_mult(corners[i], corners[j], er, ee, -1, $sformatf("corner%0d_%0d", i, j));
      end
    end

    // Random signed pairs, a quarter of them drawn from small magnitudes.
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      if ((n % 4) == 0) begin
        ra = 32'($urandom_range(0, 400)) - 32'd200;
        rb = 32'($urandom_range(0, 400)) - 32'd200;
      end
      model(ra, rb, er, ee);
      do_mult(ra, rb, er, ee, -1, $sformatf("rand%0d a=%0h b=%0h", n, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/booth_mult_sequencer.md
Name: booth_mult_sequencer

Overview:
Multi-cycle signed radix-4 Booth multiplier controller for the multdiv unit. Latches two operands and steps one Booth digit per cycle through a partial-product select/add datapath. Accumulates a 2*WIDTH product and reports the low WIDTH bits, a result-ready pulse and an overflow exception. Sits between the pipeline's multdiv issue logic and the shared adder datapath, and is the only sequencer driving that datapath.

Parameters:
WIDTH, 32, operand/result width; must be even and >= 4.
STEPS, WIDTH/2, Booth iterations per multiply; derived, not overridden.

Ports:
clock  in  1  single clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
ctrl_mult  in  1  start request; sampled each rising edge.
data_operandA  in  WIDTH  multiplicand, signed two's complement.
data_operandB  in  WIDTH  multiplier, signed two's complement.
data_result  out  WIDTH  low WIDTH bits of the product.
data_resultRDY  out  1  one-cycle pulse: result and exception valid.
data_exception  out  1  signed overflow flag; valid with data_resultRDY.
busy  out  1  high while a multiply is in progress.

Behaviour:
- Reset (async assert, sync release) drives state=IDLE, counter=0, accumulator=0, data_result=0, data_resultRDY=0, data_exception=0, busy=0. Assertion mid-operation aborts the multiply immediately, with no result pulse.
- States: IDLE, RUN, DONE.
- IDLE: when ctrl_mult=1, latch M=A and Q={B,1'b0} (WIDTH+1 bits, implicit q[-1]=0), clear the 2*WIDTH accumulator and counter, set busy=1, go to RUN.
- RUN: each cycle take booth_op = Q[2:0] and select the partial product:
  - 000 or 111: 0
  - 001 or 010: +M
  - 011: +2M
  - 100: -2M
  - 101 or 110: -M
  - The partial product is sign-extended to 2*WIDTH and shifted left by 2*counter.
  - Negation is one's complement plus carry-in = 1 into the adder.
  - The accumulator adds the shifted partial product mod 2^(2*WIDTH).
  - Q arithmetic-shifts right by 2 and counter increments.
  - After iteration STEPS-1, go to DONE.
- DONE (one cycle): data_result = acc[WIDTH-1:0]; data_exception = 1 iff acc[2*WIDTH-1:WIDTH-1] is not all-0 or all-1; data_resultRDY=1; busy=0; next state IDLE.
- data_result and data_exception hold their values until the next DONE or reset. data_resultRDY is high only in the DONE cycle.
- Latency: ctrl_mult sampled at edge 0; data_resultRDY high in the cycle after edge STEPS+1 (17 edges for WIDTH=32). Throughput is one multiply per STEPS+2 cycles.
- ctrl_mult during RUN or DONE is ignored: no restart, no queuing. Operand inputs are sampled only on acceptance.
- +2M uses the true 2*WIDTH shift, so the most negative multiplicand (0x80000000) gives the exact product.
- Counter width is ceil(log2(STEPS)). The counter never wraps during a valid operation, and it is cleared on acceptance.

Decomposition:
- Shared multdiv package/header:
  - Booth op encodings (BOOTH_ZERO, BOOTH_PM, BOOTH_P2M, BOOTH_M2M, BOOTH_MM)
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - WIDTH default
- One sub-module, booth_pp_step: combinational. Takes booth_op, M and shift amount; produces the 2*WIDTH partial product plus negate/carry-in. The sequencer owns all registers and the FSM.

Test Plan:
- Reset, then ctrl_mult with A=3, B=4 -> data_resultRDY pulse 17 cycles later, data_result=12, data_exception=0, busy high for cycles 1-16.
- A=-7 (0xFFFFFFF9), B=6 -> data_result=0xFFFFFFD6 (-42), exception=0. A=0x80000000, B=1 -> 0x80000000, exception=0.
- A=0x7FFFFFFF, B=2 -> data_result=0xFFFFFFFE, exception=1. A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, exception=1.
- Start A=5, B=5, then pulse ctrl_mult with A=9, B=9 at cycle 8 -> ignored, result=25 at the original time. A start in the cycle after RDY is accepted.
- Assert reset_n=0 at cycle 10 of a multiply -> all outputs 0 asynchronously, no RDY pulse. After release, a new 6*7 returns 42.
- Randomized 1000 signed pairs plus corner pairs {0, 1, -1, 0x7FFFFFFF, 0x80000000}, compared against a 64-bit reference model -> low 32 bits and overflow flag match.
